cmp_result_tracker: RTL

//  Downstream consumer of the 4-bit magnitude comparator's one-hot flags (eq/lt/gt).

---
 rtl/cmp_result_tracker.sv | 80 ++++++++
 1 files changed

// File: rtl/cmp_result_tracker.sv
// cmp_result_tracker: debounces one-hot eq/lt/gt compare flags into a stable relation, counts classes, flags illegal samples
module cmp_result_tracker #(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             eq,
  input  logic             lt,
  input  logic             gt,
  input  logic             clr,
  output logic [1:0]       state,
  output logic             state_chg,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [CNT_W-1:0] cnt_gt,
  output logic             err
);
  typedef enum logic [1:0] {S_UNK = 2'd0, S_LT = 2'd1, S_EQ = 2'd2, S_GT = 2'd3} state_t;
  localparam logic [3:0] DB = 4'(DEBOUNCE);
  state_t           r_state, w_state_nxt, r_cand, w_cls;
  logic [3:0]       r_run, w_run_nxt;
  logic             r_state_chg, r_err, w_legal, w_acc;
  logic [CNT_W-1:0] r_cnt_eq, r_cnt_lt, r_cnt_gt;
  assign w_legal   = (eq ^ lt ^ gt) & ~(eq & lt & gt);
  assign w_acc     = in_valid & w_legal;
  assign w_cls     = lt ? S_LT : (eq ? S_EQ : S_GT);
  // run saturates at DB so a long streak keeps qualifying without wrapping
  assign w_run_nxt = (w_cls != r_cand) ? 4'd1 : ((r_run >= DB) ? DB : r_run + 4'd1);
  always_comb begin
    w_state_nxt = r_state;
    if (w_acc && w_run_nxt == DB && w_cls != r_state) w_state_nxt = w_cls;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_UNK;
      r_state_chg <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_state_chg <= (w_state_nxt != r_state);
    end
  end
  // illegal samples leave the streak untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand <= S_UNK;
      r_run  <= 4'd0;
    end else if (w_acc) begin
      r_cand <= w_cls;
      r_run  <= w_run_nxt;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_eq <= '0;
      r_cnt_lt <= '0;
      r_cnt_gt <= '0;
      r_err    <= 1'b0;
    end else if (clr) begin
      r_cnt_eq <= '0;
      r_cnt_lt <= '0;
      r_cnt_gt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_acc) begin
        r_cnt_eq <= r_cnt_eq + CNT_W'(w_cls == S_EQ && r_cnt_eq != '1);
        r_cnt_lt <= r_cnt_lt + CNT_W'(w_cls == S_LT && r_cnt_lt != '1);
        r_cnt_gt <= r_cnt_gt + CNT_W'(w_cls == S_GT && r_cnt_gt != '1);
      end
      if (in_valid && !w_legal) r_err <= 1'b1;
    end
  end
  assign state     = r_state;
  assign state_chg = r_state_chg;
  assign cnt_eq    = r_cnt_eq;
  assign cnt_lt    = r_cnt_lt;
  assign cnt_gt    = r_cnt_gt;
  assign err       = r_err;
endmodule
